// File: rtl/result_bus_arbiter.sv
// rtl/result_bus_arbiter.sv - result bus arbiter: one driver per transaction, settle, load strobe, release
// Define RESULT_BUS_FIXED_PRIO_EN for fixed lowest-index priority; round-robin otherwise.
module result_bus_arbiter #(
   parameter int NUM_REQ       = 5,
   parameter int BUS_WIDTH     = 8,
   parameter int SETTLE_CYCLES = 3,
   parameter int HOLD_CYCLES   = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*BUS_WIDTH-1:0] src_data,
   output logic [NUM_REQ-1:0]           grant,
   output logic [BUS_WIDTH-1:0]         bus_out,
   output logic                         bus_valid,
   output logic                         load_strobe,
   output logic [NUM_REQ-1:0]           done,
   output logic                         busy
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SETTLE  = 2'd1;
   localparam logic [1:0] ST_LOAD    = 2'd2;
   localparam logic [1:0] ST_RELEASE = 2'd3;

   localparam int         PTR_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
   localparam logic [3:0] HOLD_INIT   = 4'(HOLD_CYCLES - 1);

   generate
      if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
         $error("result_bus_arbiter: SETTLE_CYCLES must be in 1..15");
      end
      if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
         $error("result_bus_arbiter: HOLD_CYCLES must be in 1..15");
      end
   endgenerate

   logic [1:0]         state;
   logic [3:0]         cnt;
   logic [NUM_REQ-1:0] pick;
   logic               pick_any;

`ifdef RESULT_BUS_FIXED_PRIO_EN
   always_comb begin
      pick     = '0;
      pick_any = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!pick_any && req[i]) begin
            pick[i]  = 1'b1;
            pick_any = 1'b1;
         end
      end
   end
`else
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] rr_ptr_nxt;
   logic [PTR_W:0]   idx;

   // Scan from rr_ptr upward, wrapping modulo NUM_REQ; first requester wins.
   always_comb begin
      pick       = '0;
      pick_any   = 1'b0;
      rr_ptr_nxt = rr_ptr;
      idx        = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
         if (idx >= (PTR_W+1)'(NUM_REQ)) begin
            idx = idx - (PTR_W+1)'(NUM_REQ);
         end
         if (!pick_any && req[idx[PTR_W-1:0]]) begin
            pick[idx[PTR_W-1:0]] = 1'b1;
            pick_any             = 1'b1;
            rr_ptr_nxt           = (idx == (PTR_W+1)'(NUM_REQ - 1)) ? '0
                                                                    : idx[PTR_W-1:0] + PTR_W'(1);
         end
      end
   end

   // Pointer moves at grant time, so an aborted transaction still yields its turn.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (state == ST_IDLE && pick_any) begin
         rr_ptr <= rr_ptr_nxt;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         grant <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  grant <= pick;
                  cnt   <= SETTLE_INIT;
                  state <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               // Owner withdrew its request: release without strobing the load.
               if ((req & grant) == '0) begin
                  grant <= '0;
                  cnt   <= HOLD_INIT;
                  state <= ST_RELEASE;
               end else if (cnt == 4'd0) begin
                  state <= ST_LOAD;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_LOAD: begin
               grant <= '0;
               cnt   <= HOLD_INIT;
               state <= ST_RELEASE;
            end
            ST_RELEASE: begin
               if (cnt == 4'd0) begin
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               grant <= '0;
               cnt   <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // grant is one-hot or zero, so OR-ing the gated lanes is a clean mux.
   always_comb begin
      bus_out = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            bus_out = bus_out | src_data[i*BUS_WIDTH +: BUS_WIDTH];
         end
      end
   end

   assign bus_valid   = (state == ST_LOAD);
   assign load_strobe = (state == ST_LOAD);
   assign done        = (state == ST_LOAD) ? grant : '0;
   assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_result_bus_arbiter.sv
// tb/tb_result_bus_arbiter.sv - directed self-checking bench for result_bus_arbiter
module tb_result_bus_arbiter;

   logic        clk;
   logic        rst;
   logic [4:0]  req;
   logic [39:0] src_data;
   logic [4:0]  grant;
   logic [7:0]  bus_out;
   logic        bus_valid;
   logic        load_strobe;
   logic [4:0]  done;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] dat [5];

`ifdef RESULT_BUS_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   result_bus_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .src_data    (src_data),
      .grant       (grant),
      .bus_out     (bus_out),
      .bus_valid   (bus_valid),
      .load_strobe (load_strobe),
      .done        (done),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [20:0] obs();
      return {grant, bus_out, bus_valid, load_strobe, done, busy};
   endfunction

   function automatic logic [20:0] pack(input logic [4:0] g, input logic [7:0] b,
                                        input logic v, input logic l,
                                        input logic [4:0] d, input logic bz);
      return {g, b, v, l, d, bz};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [20:0] ov;
      rst = 1'b1;
      req = 5'b11111;
      for (int c = 0; c < 3; c++) begin
         step();
         ov = obs();
         n_vec++;
         if (ov !== 21'd0) begin
            n_err++;
            $display("FAIL reset_hold c%0d: got %h want %h", c, ov, 21'd0);
         end
      end
      req = '0;
      rst = 1'b0;
      step();
      ov = obs();
      n_vec++;
      if (ov !== 21'd0) begin
         n_err++;
         $display("FAIL reset_idle: got %h want %h", ov, 21'd0);
      end
   endtask

   task automatic test_single();
      logic [20:0] ov, ev;
      do_reset();
      req = 5'b00100;
      for (int c = 1; c <= 7; c++) begin
         step();
         case (c)
            1, 2, 3: ev = pack(5'b00100, 8'hA5, 1'b0, 1'b0, 5'b00000, 1'b1);
            4:       ev = pack(5'b00100, 8'hA5, 1'b1, 1'b1, 5'b00100, 1'b1);
            5:       ev = pack(5'b00000, 8'h00, 1'b0, 1'b0, 5'b00000, 1'b1);
            default: ev = pack(5'b00000, 8'h00, 1'b0, 1'b0, 5'b00000, 1'b0);
         endcase
         ov = obs();
         n_vec++;
         if (ov !== ev) begin
            n_err++;
            $display("FAIL single c%0d: got %h want %h", c, ov, ev);
         end
         if (c == 4) req = '0;
      end
   endtask

   task automatic test_round_robin();
      logic [4:0] eg;
      int         k;
      do_reset();
      req = 5'b11111;
      for (int c = 1; c <= 31; c++) begin
         step();
         k  = (c - 1) / 6;
         eg = 5'b00001 << (k % 5);
         if (c % 6 == 1) begin
            n_vec++;
            if (grant !== eg || bus_out !== dat[k % 5]) begin
               n_err++;
               $display("FAIL rr_grant c%0d: got %b/%h want %b/%h", c, grant, bus_out, eg, dat[k % 5]);
            end
         end
         if (c % 6 == 4) begin
            n_vec++;
            if (load_strobe !== 1'b1 || done !== eg) begin
               n_err++;
               $display("FAIL rr_load c%0d: got ls=%b done=%b want ls=1 done=%b", c, load_strobe, done, eg);
            end
         end
         if (c % 6 == 0) begin
            n_vec++;
            if (busy !== 1'b0 || grant !== 5'b0) begin
               n_err++;
               $display("FAIL rr_idle c%0d: got busy=%b grant=%b want 0/00000", c, busy, grant);
            end
         end
      end
      req = '0;
   endtask

   task automatic test_wrap();
      do_reset();
      req = 5'b01000;
      for (int c = 1; c <= 13; c++) begin
         step();
         if (c == 1) begin
            n_vec++;
            if (grant !== 5'b01000) begin
               n_err++;
               $display("FAIL wrap_first: got %b want %b", grant, 5'b01000);
            end
         end
         if (c == 4) req = 5'b10001;
         if (c == 7) begin
            n_vec++;
            if (grant !== 5'b10000 || bus_out !== dat[4]) begin
               n_err++;
               $display("FAIL wrap_g4: got %b/%h want %b/%h", grant, bus_out, 5'b10000, dat[4]);
            end
         end
         if (c == 13) begin
            n_vec++;
            if (grant !== 5'b00001 || bus_out !== dat[0]) begin
               n_err++;
               $display("FAIL wrap_g0: got %b/%h want %b/%h", grant, bus_out, 5'b00001, dat[0]);
            end
         end
      end
      req = '0;
   endtask

   task automatic test_abort();
      logic [20:0] ov, ev;
      logic [4:0]  eg;
      logic [7:0]  eb;
      eg = FIXED ? 5'b00010 : 5'b10000;
      eb = FIXED ? dat[1] : dat[4];
      do_reset();
      req = 5'b01000;
      for (int c = 1; c <= 8; c++) begin
         step();
         case (c)
            1, 2:    ev = pack(5'b01000, dat[3], 1'b0, 1'b0, 5'b0, 1'b1);
            3:       ev = pack(5'b00000, 8'h00,  1'b0, 1'b0, 5'b0, 1'b1);
            4:       ev = pack(5'b00000, 8'h00,  1'b0, 1'b0, 5'b0, 1'b0);
            8:       ev = pack(eg, eb, 1'b1, 1'b1, eg, 1'b1);
            default: ev = pack(eg, eb, 1'b0, 1'b0, 5'b0, 1'b1);
         endcase
         ov = obs();
         n_vec++;
         if (ov !== ev) begin
            n_err++;
            $display("FAIL abort c%0d: got %h want %h", c, ov, ev);
         end
         if (c == 2) req = 5'b10010;
      end
      req = '0;
   endtask

   task automatic test_reset_mid();
      logic [20:0] ov;
      do_reset();
      req = 5'b00100;
      for (int c = 1; c <= 4; c++) begin
         step();
         if (c == 1) begin
            n_vec++;
            if (grant !== 5'b00100) begin
               n_err++;
               $display("FAIL rstmid_grant: got %b want %b", grant, 5'b00100);
            end
         end
         if (c == 2) rst = 1'b1;
         if (c == 3) begin
            ov = obs();
            n_vec++;
            if (ov !== 21'd0) begin
               n_err++;
               $display("FAIL rstmid_zero: got %h want %h", ov, 21'd0);
            end
            rst = 1'b0;
            req = 5'b11111;
         end
         if (c == 4) begin
            n_vec++;
            if (grant !== 5'b00001 || bus_out !== dat[0]) begin
               n_err++;
               $display("FAIL rstmid_ptr: got %b/%h want %b/%h", grant, bus_out, 5'b00001, dat[0]);
            end
         end
      end
      req = '0;
   endtask

   task automatic test_fixed_prio();
      do_reset();
      req = 5'b11010;
      for (int c = 1; c <= 19; c++) begin
         step();
         if (c % 6 == 1) begin
            n_vec++;
            if (grant !== 5'b00010 || bus_out !== dat[1]) begin
               n_err++;
               $display("FAIL fixed_grant c%0d: got %b/%h want %b/%h", c, grant, bus_out, 5'b00010, dat[1]);
            end
         end
         if (c % 6 == 4) begin
            n_vec++;
            if (done !== 5'b00010) begin
               n_err++;
               $display("FAIL fixed_done c%0d: got %b want %b", c, done, 5'b00010);
            end
         end
      end
      req = '0;
   endtask

   initial begin
      dat[0] = 8'h3C;
      dat[1] = 8'h5A;
      dat[2] = 8'hA5;
      dat[3] = 8'hC3;
      dat[4] = 8'h96;
      src_data = {dat[4], dat[3], dat[2], dat[1], dat[0]};
      rst = 1'b1;
      req = '0;
      test_reset();
      test_single();
      test_abort();
      test_reset_mid();
`ifdef RESULT_BUS_FIXED_PRIO_EN
      test_fixed_prio();
`else
      test_round_robin();
      test_wrap();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
